// File: rtl/rv_core_pkg.sv
// Shared encodings and widths for the multi-cycle RV32I/RV32E core datapath.
package rv_core_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned REG_IDX_W = 5;
  localparam int unsigned STAGE_W   = 5;

  // Control FSM stage codes used by the register file
  localparam logic [STAGE_W-1:0] STAGE_DECODE = 5'd1;
  localparam logic [STAGE_W-1:0] STAGE_WB     = 5'd3;

  // Write-back data select
  localparam logic [1:0] MTOR_ALU  = 2'b00;
  localparam logic [1:0] MTOR_DATA = 2'b01;
  localparam logic [1:0] MTOR_PC4  = 2'b10;
  localparam logic [1:0] MTOR_IMM  = 2'b11;

  // ALU operand B select
  localparam logic [1:0] SRCB_RSB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_ZERO = 2'b11;

  // Clearing-sweep controller states
  typedef enum logic {
    SW_INIT = 1'b0,
    SW_RUN  = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/regfile_array.sv
// NREGS x XLEN register storage: one synchronous write port, three
// combinational read ports. Index 0 and indices >= NREGS read as zero and
// are never written.
// Ports:
//   clk                       rising-edge clock
//   i_we/i_waddr/i_wdata      write port
//   i_raddr_a/_b/_d           read indices (rs1, rs2, debug)
//   o_rdata_a/_b/_d           read data
module regfile_array
  import rv_core_pkg::*;
#(
  parameter int unsigned XLEN  = rv_core_pkg::XLEN,
  parameter int unsigned NREGS = 32
) (
  input  logic                 clk,
  input  logic                 i_we,
  input  logic [REG_IDX_W-1:0] i_waddr,
  input  logic [XLEN-1:0]      i_wdata,
  input  logic [REG_IDX_W-1:0] i_raddr_a,
  input  logic [REG_IDX_W-1:0] i_raddr_b,
  input  logic [REG_IDX_W-1:0] i_raddr_d,
  output logic [XLEN-1:0]      o_rdata_a,
  output logic [XLEN-1:0]      o_rdata_b,
  output logic [XLEN-1:0]      o_rdata_d
);

  localparam int unsigned          IDX_W = $clog2(NREGS);
  localparam logic [REG_IDX_W:0]   LIM   = (REG_IDX_W+1)'(NREGS);

  logic [XLEN-1:0] r_mem [NREGS];

  // True for an index that names real, writable storage
  function automatic logic in_range(input logic [REG_IDX_W-1:0] a);
    return (a != '0) && ({1'b0, a} < LIM);
  endfunction

  // Storage has no reset; the top-level sweep clears it
  always_ff @(posedge clk) begin
    if (i_we && in_range(i_waddr)) begin
      r_mem[i_waddr[IDX_W-1:0]] <= i_wdata;
    end
  end

  assign o_rdata_a = in_range(i_raddr_a) ? r_mem[i_raddr_a[IDX_W-1:0]] : '0;
  assign o_rdata_b = in_range(i_raddr_b) ? r_mem[i_raddr_b[IDX_W-1:0]] : '0;
  assign o_rdata_d = in_range(i_raddr_d) ? r_mem[i_raddr_d[IDX_W-1:0]] : '0;

endmodule

// File: rtl/regfile_operand_unit.sv
// Integer register file with operand latching for the multi-cycle core.
// Latches rsA/rsB at DECODE, drives ALU operand muxes SrcA/SrcB, selects and
// commits write-back data at WB. After reset a sweep zeroes every register
// before ready rises.
// Ports:
//   clk, reset (sync, active-low)
//   current_stage, RegWrite, MtoR, AluSrcA, AluSrcB   control
//   rs1, rs2, rd, dbg_addr                            register indices
//   data, AluOut, pc, Imm                             datapath inputs
//   wr_data, SrcA, SrcB, dbg_data                     combinational outputs
//   rsA, rsB, ready, illegal_reg                      registered outputs
module regfile_operand_unit
  import rv_core_pkg::*;
#(
  parameter int unsigned XLEN      = rv_core_pkg::XLEN,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned STAGE_W   = rv_core_pkg::STAGE_W,
  parameter int unsigned ST_DECODE = 32'(STAGE_DECODE),
  parameter int unsigned ST_WB     = 32'(STAGE_WB)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [STAGE_W-1:0]   current_stage,
  input  logic                 RegWrite,
  input  logic [1:0]           MtoR,
  input  logic                 AluSrcA,
  input  logic [1:0]           AluSrcB,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic [REG_IDX_W-1:0] rd,
  input  logic [XLEN-1:0]      data,
  input  logic [XLEN-1:0]      AluOut,
  input  logic [XLEN-1:0]      pc,
  input  logic [XLEN-1:0]      Imm,
  input  logic [REG_IDX_W-1:0] dbg_addr,
  output logic [XLEN-1:0]      wr_data,
  output logic [XLEN-1:0]      rsA,
  output logic [XLEN-1:0]      rsB,
  output logic [XLEN-1:0]      SrcA,
  output logic [XLEN-1:0]      SrcB,
  output logic [XLEN-1:0]      dbg_data,
  output logic                 ready,
  output logic                 illegal_reg
);

  localparam logic [REG_IDX_W:0]   LIM  = (REG_IDX_W+1)'(NREGS);
  localparam logic [REG_IDX_W-1:0] LAST = REG_IDX_W'(NREGS - 1);

  sweep_state_e         r_state;
  logic [REG_IDX_W-1:0] r_cnt;

  logic                 w_wb_req;
  logic                 w_func_we;
  logic                 w_illegal;
  logic                 w_latch;
  logic                 w_arr_we;
  logic [REG_IDX_W-1:0] w_arr_waddr;
  logic [XLEN-1:0]      w_arr_wdata;
  logic [XLEN-1:0]      w_rd_a;
  logic [XLEN-1:0]      w_rd_b;

  // Functional write request, legal-commit and illegal-target qualifiers
  assign w_wb_req  = (r_state == SW_RUN) && (current_stage == STAGE_W'(ST_WB)) && RegWrite;
  assign w_func_we = w_wb_req && (rd != '0) && ({1'b0, rd} < LIM);
  assign w_illegal = w_wb_req && ({1'b0, rd} >= LIM);
  assign w_latch   = (r_state == SW_RUN) && (current_stage == STAGE_W'(ST_DECODE));

  // Sweep owns the write port during INIT; nothing commits while reset is low
  assign w_arr_we    = reset && ((r_state == SW_INIT) || w_func_we);
  assign w_arr_waddr = (r_state == SW_INIT) ? r_cnt : rd;
  assign w_arr_wdata = (r_state == SW_INIT) ? '0 : wr_data;

  regfile_array #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_array (
    .clk       (clk),
    .i_we      (w_arr_we),
    .i_waddr   (w_arr_waddr),
    .i_wdata   (w_arr_wdata),
    .i_raddr_a (rs1),
    .i_raddr_b (rs2),
    .i_raddr_d (dbg_addr),
    .o_rdata_a (w_rd_a),
    .o_rdata_b (w_rd_b),
    .o_rdata_d (dbg_data)
  );

  // Write-back data select; pc+4 wraps naturally at XLEN bits
  always_comb begin
    wr_data = '0;
    case (MtoR)
      MTOR_ALU:  wr_data = AluOut;
      MTOR_DATA: wr_data = data;
      MTOR_PC4:  wr_data = pc + XLEN'(4);
      MTOR_IMM:  wr_data = Imm;
      default:   wr_data = '0;
    endcase
  end

  assign SrcA = AluSrcA ? rsA : pc;

  always_comb begin
    SrcB = '0;
    case (AluSrcB)
      SRCB_RSB:  SrcB = rsB;
      SRCB_FOUR: SrcB = XLEN'(4);
      SRCB_IMM:  SrcB = Imm;
      SRCB_ZERO: SrcB = '0;
      default:   SrcB = '0;
    endcase
  end

  // Sweep FSM, operand latches (write-first bypass) and sticky error flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= SW_INIT;
      r_cnt       <= REG_IDX_W'(1);
      rsA         <= '0;
      rsB         <= '0;
      ready       <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      case (r_state)
        SW_INIT: begin
          r_cnt <= r_cnt + REG_IDX_W'(1);
          if (r_cnt == LAST) begin
            r_state <= SW_RUN;
            ready   <= 1'b1;
          end
        end
        SW_RUN: begin
          if (w_illegal) begin
            illegal_reg <= 1'b1;
          end
          if (w_latch) begin
            rsA <= (w_func_we && (rd == rs1)) ? wr_data : w_rd_a;
            rsB <= (w_func_we && (rd == rs2)) ? wr_data : w_rd_b;
          end
        end
        default: begin
          r_state <= SW_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_operand_unit.sv
// Directed bench for regfile_operand_unit. Two instances share the stimulus:
// u_dut uses the default configuration; u_dut16 has NREGS=16 and WB coded
// as the DECODE stage so that a commit and an operand latch share an edge.
module tb_regfile_operand_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  current_stage;
  logic        RegWrite;
  logic [1:0]  MtoR;
  logic        AluSrcA;
  logic [1:0]  AluSrcB;
  logic [4:0]  rs1, rs2, rd, dbg_addr;
  logic [31:0] data, AluOut, pc, Imm;

  logic [31:0] wr_data, rsA, rsB, SrcA, SrcB, dbg_data;
  logic        ready, illegal_reg;
  logic [31:0] wr_data16, rsA16, rsB16, SrcA16, SrcB16, dbg_data16;
  logic        ready16, illegal16;

  int total = 0;
  int bad   = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  regfile_operand_unit u_dut (
    .clk(clk), .reset(reset), .current_stage(current_stage), .RegWrite(RegWrite),
    .MtoR(MtoR), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .rs1(rs1), .rs2(rs2), .rd(rd),
    .data(data), .AluOut(AluOut), .pc(pc), .Imm(Imm), .dbg_addr(dbg_addr),
    .wr_data(wr_data), .rsA(rsA), .rsB(rsB), .SrcA(SrcA), .SrcB(SrcB),
    .dbg_data(dbg_data), .ready(ready), .illegal_reg(illegal_reg)
  );

  regfile_operand_unit #(.NREGS(16), .ST_WB(1)) u_dut16 (
    .clk(clk), .reset(reset), .current_stage(current_stage), .RegWrite(RegWrite),
    .MtoR(MtoR), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .rs1(rs1), .rs2(rs2), .rd(rd),
    .data(data), .AluOut(AluOut), .pc(pc), .Imm(Imm), .dbg_addr(dbg_addr),
    .wr_data(wr_data16), .rsA(rsA16), .rsB(rsB16), .SrcA(SrcA16), .SrcB(SrcB16),
    .dbg_data(dbg_data16), .ready(ready16), .illegal_reg(illegal16)
  );

  task automatic expect_val(input string t, input logic [31:0] v);
    q.push_back('{t, v});
  endtask

  task automatic got(input logic [31:0] obs);
    exp_t e;
    total++;
    if (q.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    current_stage = 5'd0;
    RegWrite      = 1'b0;
  endtask

  initial begin
    reset = 1'b0; idle();
    MtoR = 2'b00; AluSrcA = 1'b0; AluSrcB = 2'b00;
    rs1 = '0; rs2 = '0; rd = '0; dbg_addr = '0;
    data = '0; AluOut = '0; pc = '0; Imm = '0;

    // Reset state
    step(); step();
    expect_val("rst_ready", 32'd0);   got(32'(ready));
    expect_val("rst_rsA", 32'd0);     got(rsA);
    expect_val("rst_rsB", 32'd0);     got(rsB);
    expect_val("rst_illegal", 32'd0); got(32'(illegal_reg));

    // Partial sweep, then reset re-asserted: sweep must restart from 1
    reset = 1'b1;
    for (int e = 1; e <= 10; e++) step();
    expect_val("partial_ready16", 32'd0); got(32'(ready16));
    reset = 1'b0;
    step();
    reset = 1'b1;
    // Functional write attempted throughout INIT; must be ignored
    current_stage = 5'd3; RegWrite = 1'b1; rd = 5'd2; MtoR = 2'b00; AluOut = 32'h55AA_55AA;
    for (int e = 1; e <= 30; e++) begin
      step();
      expect_val($sformatf("sweep_ready_e%0d", e), 32'd0); got(32'(ready));
      if (e == 14) begin expect_val("sweep_ready16_e14", 32'd0); got(32'(ready16)); end
      if (e == 15) begin expect_val("sweep_ready16_e15", 32'd1); got(32'(ready16)); end
    end
    idle();
    step();
    expect_val("sweep_ready_e31", 32'd1); got(32'(ready));

    // Every register reads zero after the sweep
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      expect_val($sformatf("clr_dbg%0d", i), 32'd0);   got(dbg_data);
      expect_val($sformatf("clr_dbg16_%0d", i), 32'd0); got(dbg_data16);
      step();
    end

    // Write-back paths
    current_stage = 5'd3; RegWrite = 1'b1; rd = 5'd25; MtoR = 2'b00; AluOut = 32'h0052_3100;
    #1; expect_val("wr_alu", 32'h0052_3100); got(wr_data);
    step(); idle(); dbg_addr = 5'd25;
    #1; expect_val("dbg25", 32'h0052_3100); got(dbg_data);
    current_stage = 5'd3; RegWrite = 1'b1; rd = 5'd9; MtoR = 2'b01; data = 32'h0000_1111;
    step(); idle(); dbg_addr = 5'd9;
    #1; expect_val("dbg9", 32'h0000_1111); got(dbg_data);
    MtoR = 2'b10; pc = 32'h0000_1126;
    #1; expect_val("wr_pc4", 32'h0000_112A); got(wr_data);
    pc = 32'hFFFF_FFFE;
    #1; expect_val("wr_pc4_wrap", 32'h0000_0002); got(wr_data);
    step();
    MtoR = 2'b11; Imm = 32'h8000_0001;
    #1; expect_val("wr_imm", 32'h8000_0001); got(wr_data);

    // x0 write dropped; INIT-time write left no trace
    current_stage = 5'd3; RegWrite = 1'b1; rd = 5'd0; MtoR = 2'b00; AluOut = 32'hDEAD_BEEF;
    step(); idle(); dbg_addr = 5'd0;
    #1; expect_val("dbg0", 32'd0); got(dbg_data);
    dbg_addr = 5'd2;
    #1; expect_val("dbg2_init_write", 32'd0); got(dbg_data);
    step();

    // Operand latch and ALU muxes
    current_stage = 5'd3; RegWrite = 1'b1; MtoR = 2'b11; rd = 5'd20; Imm = 32'h1115_2100;
    step();
    rd = 5'd21; Imm = 32'h3610_0321;
    step();
    idle(); current_stage = 5'd1; rs1 = 5'd20; rs2 = 5'd21; AluSrcA = 1'b1; AluSrcB = 2'b00;
    step(); idle();
    expect_val("rsA", 32'h1115_2100);  got(rsA);
    expect_val("rsB", 32'h3610_0321);  got(rsB);
    expect_val("SrcA_rs", 32'h1115_2100); got(SrcA);
    expect_val("SrcB_rs", 32'h3610_0321); got(SrcB);
    AluSrcA = 1'b0; pc = 32'h0000_4326;
    #1; expect_val("SrcA_pc", 32'h0000_4326); got(SrcA);
    AluSrcB = 2'b10; Imm = 32'h0000_1100;
    #1; expect_val("SrcB_imm", 32'h0000_1100); got(SrcB);
    step();
    AluSrcB = 2'b01;
    #1; expect_val("SrcB_four", 32'd4); got(SrcB);
    AluSrcB = 2'b11;
    #1; expect_val("SrcB_zero", 32'd0); got(SrcB);
    current_stage = 5'd2; rs1 = 5'd25;
    step();
    expect_val("rsA_hold", 32'h1115_2100); got(rsA);

    // Same-edge commit and latch on the NREGS=16 instance
    current_stage = 5'd1; RegWrite = 1'b1; rd = 5'd5; rs1 = 5'd5; rs2 = 5'd6;
    MtoR = 2'b00; AluOut = 32'hCAFE_F00D;
    step(); idle();
    expect_val("bypass_rsA16", 32'hCAFE_F00D); got(rsA16);
    expect_val("bypass_rsB16", 32'd0);         got(rsB16);
    dbg_addr = 5'd5;
    #1; expect_val("bypass_dbg16", 32'hCAFE_F00D); got(dbg_data16);
    expect_val("no_write_dbg5", 32'd0); got(dbg_data);

    // Out-of-range destination on NREGS=16
    current_stage = 5'd1; RegWrite = 1'b1; rd = 5'd17; AluOut = 32'h1234_5678;
    rs1 = 5'd0; rs2 = 5'd0;
    step(); idle();
    expect_val("illegal16", 32'd1); got(32'(illegal16));
    expect_val("illegal32", 32'd0); got(32'(illegal_reg));
    dbg_addr = 5'd1;
    #1; expect_val("alias_dbg16_1", 32'd0); got(dbg_data16);
    step();
    dbg_addr = 5'd5;
    #1; expect_val("keep_dbg16_5", 32'hCAFE_F00D); got(dbg_data16);
    dbg_addr = 5'd17;
    #1; expect_val("oor_dbg16_17", 32'd0); got(dbg_data16);
    step();

    // Reset mid-run
    reset = 1'b0;
    step();
    expect_val("rerst_ready16", 32'd0);   got(32'(ready16));
    expect_val("rerst_illegal16", 32'd0); got(32'(illegal16));
    expect_val("rerst_ready", 32'd0);     got(32'(ready));
    expect_val("rerst_rsA16", 32'd0);     got(rsA16);
    reset = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      step();
      if (e == 14) begin expect_val("resweep_ready16_e14", 32'd0); got(32'(ready16)); end
      if (e == 15) begin expect_val("resweep_ready16_e15", 32'd1); got(32'(ready16)); end
    end
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 5'(i);
      #1; expect_val($sformatf("resweep_dbg16_%0d", i), 32'd0); got(dbg_data16);
      step();
    end
    expect_val("resweep_ready", 32'd1); got(32'(ready));
    dbg_addr = 5'd25;
    #1; expect_val("resweep_dbg25", 32'd0); got(dbg_data);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
